// File: rtl/mult_fu.sv
// mult_fu: pipelined RV32M multiply unit, one op per cycle, result STAGES cycles after issue.
// Latency STAGES cycles (+1 per stall cycle); a stalled output freezes the pipe and drops free.
// MULT_COLLAPSE_EN: on stall only the valid run ending at the output holds, so bubbles get filled.
package mult_fu_pkg;
  typedef logic [31:0] DATA;
  typedef logic [3:0]  BR_MASK;
  typedef enum logic [1:0] {BR_NONE = 2'd0, SQUASH = 2'd1, CLEAR = 2'd2} BR_TASK;

  typedef struct packed {
    logic [5:0] reg_idx;
  } PHYS_TAG;

  typedef struct packed {
    logic [4:0] dest_reg_idx;
    logic       valid;
  } DECODED;

  typedef struct packed {
    BR_MASK  b_id;
    BR_MASK  b_mask;
    PHYS_TAG t;
    DECODED  decoded_vals;
  } RS_PACKET;

  typedef struct packed {
    RS_PACKET decoded_vals;
    DATA      result;
  } FU_PACKET;

  localparam logic [1:0] F_MUL    = 2'd0;
  localparam logic [1:0] F_MULH   = 2'd1;
  localparam logic [1:0] F_MULHSU = 2'd2;
  localparam logic [1:0] F_MULHU  = 2'd3;
endpackage

module mult_fu
  import mult_fu_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  RS_PACKET   rs_packet,
  input  DATA        rs1_val,
  input  DATA        rs2_val,
  input  logic [1:0] mult_func,
  input  logic       stall,
  input  BR_TASK     rem_br_task,
  input  BR_MASK     rem_b_id,
  output logic       fu_done,
  output FU_PACKET   fu_packet,
  output logic       free
);
  localparam int          W    = 64 / STAGES;
  localparam logic [63:0] MASK = (W == 64) ? {64{1'b1}} : ((64'd1 << W) - 64'd1);

  logic        r_vld    [STAGES];
  RS_PACKET    r_meta   [STAGES];
  logic [1:0]  r_func   [STAGES];
  logic [63:0] r_mcand  [STAGES];
  logic [63:0] r_mplier [STAGES];
  logic [63:0] r_sum    [STAGES];

  logic        w_src_vld    [STAGES];
  RS_PACKET    w_src_meta   [STAGES];
  logic [1:0]  w_src_func   [STAGES];
  logic [63:0] w_src_mcand  [STAGES];
  logic [63:0] w_src_mplier [STAGES];
  logic [63:0] w_src_sum    [STAGES];
  logic [63:0] w_sum_nxt    [STAGES];

  logic [STAGES-1:0] w_hold;
  logic              w_stall_out;
  logic              w_a_sgn;
  logic              w_b_sgn;

  function automatic logic br_kill(RS_PACKET m, BR_TASK t, BR_MASK id);
    return (t == SQUASH) && ((m.b_mask & id) != '0) && (m.b_id != id);
  endfunction

  function automatic RS_PACKET br_clr(RS_PACKET m, BR_TASK t, BR_MASK id);
    RS_PACKET r;
    r = m;
    if (t == CLEAR) r.b_mask = m.b_mask & ~id;
    return r;
  endfunction

  assign w_a_sgn     = (mult_func != F_MULHU);
  assign w_b_sgn     = (mult_func == F_MUL) || (mult_func == F_MULH);
  assign w_stall_out = r_vld[STAGES-1] && stall;

`ifdef MULT_COLLAPSE_EN
  // A stage holds only if it and everything downstream is valid and the output is stalled.
  always_comb begin
    w_hold = '0;
    w_hold[STAGES-1] = w_stall_out;
    for (int k = STAGES - 2; k >= 0; k--) w_hold[k] = w_hold[k+1] && r_vld[k];
  end
`else
  always_comb begin
    w_hold = '0;
    for (int k = 0; k < STAGES; k++) w_hold[k] = w_stall_out;
  end
`endif

  assign free    = !w_hold[0];
  assign fu_done = r_vld[STAGES-1];

  // Stage k consumes multiplier bits [k*W +: W]; operands are sign/zero-extended to 64 bits.
  always_comb begin
    w_src_vld[0]    = start;
    w_src_meta[0]   = rs_packet;
    w_src_func[0]   = mult_func;
    w_src_mcand[0]  = {{32{w_a_sgn & rs1_val[31]}}, rs1_val};
    w_src_mplier[0] = {{32{w_b_sgn & rs2_val[31]}}, rs2_val};
    w_src_sum[0]    = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k]    = r_vld[k-1];
      w_src_meta[k]   = r_meta[k-1];
      w_src_func[k]   = r_func[k-1];
      w_src_mcand[k]  = r_mcand[k-1];
      w_src_mplier[k] = r_mplier[k-1];
      w_src_sum[k]    = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_sum_nxt[k] = w_src_sum[k] +
                     ((w_src_mcand[k] * ((w_src_mplier[k] >> (k * W)) & MASK)) << (k * W));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]    <= 1'b0;
        r_meta[k]   <= '0;
        r_func[k]   <= '0;
        r_mcand[k]  <= '0;
        r_mplier[k] <= '0;
        r_sum[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_hold[k]) begin
          r_vld[k]  <= r_vld[k] && !br_kill(r_meta[k], rem_br_task, rem_b_id);
          r_meta[k] <= br_clr(r_meta[k], rem_br_task, rem_b_id);
        end else begin
          r_vld[k]    <= w_src_vld[k] && !br_kill(w_src_meta[k], rem_br_task, rem_b_id);
          r_meta[k]   <= br_clr(w_src_meta[k], rem_br_task, rem_b_id);
          r_func[k]   <= w_src_func[k];
          r_mcand[k]  <= w_src_mcand[k];
          r_mplier[k] <= w_src_mplier[k];
          r_sum[k]    <= w_sum_nxt[k];
        end
      end
    end
  end

  always_comb begin
    fu_packet = '0;
    if (r_vld[STAGES-1]) begin
      fu_packet.decoded_vals = r_meta[STAGES-1];
      fu_packet.result = (r_func[STAGES-1] == F_MUL) ? r_sum[STAGES-1][31:0]
                                                     : r_sum[STAGES-1][63:32];
    end
  end
endmodule

// File: tb/tb_mult_fu.sv
// Bench for mult_fu: directed branch/stall/reset scenarios plus a randomized stream
// checked against a longint arithmetic reference and an in-order expectation queue.
module tb_mult_fu;
  import mult_fu_pkg::*;

  localparam int STAGES = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  RS_PACKET   rs_packet;
  DATA        rs1_val;
  DATA        rs2_val;
  logic [1:0] mult_func;
  logic       stall;
  BR_TASK     rem_br_task;
  BR_MASK     rem_b_id;
  logic       fu_done;
  FU_PACKET   fu_packet;
  logic       free;

  logic       o_done;
  FU_PACKET   o_pkt;
  logic       o_free;

  int checks = 0;
  int errors = 0;

  mult_fu #(.STAGES(STAGES)) dut (
    .clock(clock), .reset(reset), .start(start), .rs_packet(rs_packet),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .mult_func(mult_func), .stall(stall),
    .rem_br_task(rem_br_task), .rem_b_id(rem_b_id), .fu_done(fu_done),
    .fu_packet(fu_packet), .free(free)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_mul(logic [1:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      2'd0, 2'd1: p = sa * sb;
      2'd2:       p = sa * ub;
      default:    p = ua * ub;
    endcase
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic RS_PACKET mk_meta(BR_MASK id, BR_MASK mask, logic [5:0] tag, logic [4:0] dst);
    RS_PACKET m;
    m.b_id = id;
    m.b_mask = mask;
    m.t.reg_idx = tag;
    m.decoded_vals.dest_reg_idx = dst;
    m.decoded_vals.valid = 1'b1;
    return m;
  endfunction

  function automatic FU_PACKET mk_pkt(RS_PACKET m, logic [31:0] r);
    FU_PACKET p;
    p.decoded_vals = m;
    p.result = r;
    return p;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Drive one cycle just after a negedge, sample the outputs 1 time unit later, then pass the edge.
  task automatic step(input logic s, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                      input RS_PACKET m, input logic st, input BR_TASK bt, input BR_MASK bid);
    start = s; mult_func = f; rs1_val = a; rs2_val = b; rs_packet = m;
    stall = st; rem_br_task = bt; rem_b_id = bid;
    #1;
    o_done = fu_done; o_pkt = fu_packet; o_free = free;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input logic st);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, st, BR_NONE, '0);
  endtask

  task automatic flush();
    for (int i = 0; i < STAGES + 2; i++) idle(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 0; rs_packet = '0; rs1_val = 0; rs2_val = 0; mult_func = 0;
    stall = 0; rem_br_task = BR_NONE; rem_b_id = '0;
    #1;
    checks++; if (fu_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", fu_done); end
    checks++; if (fu_packet !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", fu_packet); end
    checks++; if (free !== 1'b1) begin errors++; $display("FAIL reset_free got %b want 1", free); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_latency();
    RS_PACKET m;
    int c;
    m = mk_meta(4'b0001, 4'b0011, 6'd17, 5'd9);
    c = 0;
    step(1'b1, F_MUL, 32'd7, 32'hFFFF_FFFD, m, 1'b0, BR_NONE, '0);
    for (int i = 1; i <= 20 && c == 0; i++) begin
      idle(1'b0);
      if (o_done) c = i;
    end
    checks++; if (c !== STAGES) begin errors++; $display("FAIL latency got %0d want %0d", c, STAGES); end
    checks++; if (o_pkt.result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_7x-3 got %h want ffffffeb", o_pkt.result); end
    checks++; if (o_pkt.decoded_vals !== m) begin errors++; $display("FAIL latency_meta got %h want %h", o_pkt.decoded_vals, m); end
    flush();
  endtask

  task automatic test_back_to_back();
    logic [1:0]  fn  [4];
    logic [31:0] exp [4];
    logic        want;
    fn  = '{F_MULHU, F_MULH, F_MULHSU, F_MUL};
    exp = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < STAGES + 6; i++) begin
      if (i < 4) step(1'b1, fn[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk_meta('0, '0, 6'(i), 5'(i)), 1'b0, BR_NONE, '0);
      else idle(1'b0);
      want = (i >= STAGES) && (i < STAGES + 4);
      checks++;
      if (o_done !== want) begin
        errors++; $display("FAIL b2b_done[%0d] got %b want %b", i, o_done, want);
      end else if (want && o_pkt.result !== exp[i-STAGES]) begin
        errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, o_pkt.result, exp[i-STAGES]);
      end
    end
    flush();
  endtask

  task automatic test_stall();
    FU_PACKET exp [4];
    FU_PACKET held;
    RS_PACKET m;
    logic [31:0] a, b;
    logic [1:0] f;
    logic st;
    int n;
    n = 0;
    held = '0;
    for (int i = 0; i < 16; i++) begin
      st = (i == STAGES) || (i == STAGES + 1);
      if (i < 4) begin
        a = rand_operand(); b = rand_operand(); f = 2'($urandom_range(0, 3));
        m = mk_meta('0, '0, 6'(20 + i), 5'(i));
        exp[i] = mk_pkt(m, ref_mul(f, a, b));
        step(1'b1, f, a, b, m, st, BR_NONE, '0);
      end else idle(st);
      if (st) begin
        checks++; if (o_free !== 1'b0) begin errors++; $display("FAIL stall_free[%0d] got %b want 0", i, o_free); end
      end
      if (i == STAGES) held = o_pkt;
      if (i == STAGES + 1 || i == STAGES + 2) begin
        checks++; if (o_pkt !== held) begin errors++; $display("FAIL stall_stable[%0d] got %h want %h", i, o_pkt, held); end
      end
      if (o_done && !st) begin
        checks++;
        if (n >= 4) begin
          errors++; $display("FAIL stall_extra got %h want none", o_pkt);
        end else if (o_pkt !== exp[n]) begin
          errors++; $display("FAIL stall_order[%0d] got %h want %h", n, o_pkt, exp[n]);
        end
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL stall_count got %0d want 4", n); end
    flush();
`ifdef MULT_COLLAPSE_EN
    n = 0;
    for (int i = 0; i < 16; i++) begin
      st = (i == STAGES) || (i == STAGES + 1);
      if (i == 0 || i == 2 || i == 3) begin
        a = rand_operand(); b = rand_operand(); f = 2'($urandom_range(0, 3));
        m = mk_meta('0, '0, 6'(30 + i), 5'(i));
        exp[n] = mk_pkt(m, ref_mul(f, a, b));
        n++;
        step(1'b1, f, a, b, m, st, BR_NONE, '0);
      end else idle(st);
      if (i == STAGES) begin
        checks++; if (o_free !== 1'b1) begin errors++; $display("FAIL collapse_free got %b want 1", o_free); end
      end
    end
    flush();
`endif
  endtask

  task automatic test_squash();
    RS_PACKET m [4];
    FU_PACKET exp [$];
    logic [31:0] a [4];
    int n;
    m[0] = mk_meta(4'b0000, 4'b0010, 6'd40, 5'd1);
    m[1] = mk_meta(4'b0010, 4'b0010, 6'd41, 5'd2);
    m[2] = mk_meta(4'b0000, 4'b0010, 6'd42, 5'd3);
    m[3] = mk_meta(4'b0000, 4'b0010, 6'd43, 5'd4);
    for (int i = 0; i < 4; i++) begin
      a[i] = $urandom;
      if (!((m[i].b_mask & 4'b0010) != 0 && m[i].b_id != 4'b0010))
        exp.push_back(mk_pkt(m[i], ref_mul(F_MUL, a[i], 32'd3)));
      step(1'b1, F_MUL, a[i], 32'd3, m[i], 1'b0, BR_NONE, '0);
    end
    for (int i = 4; i < STAGES; i++) idle(1'b0);
    step(1'b0, 2'd0, 32'd0, 32'd0, '0, 1'b1, SQUASH, 4'b0010);
    checks++; if (o_done !== 1'b1 || o_pkt.decoded_vals !== m[0]) begin
      errors++; $display("FAIL squash_presented got %b/%h want 1/%h", o_done, o_pkt.decoded_vals, m[0]);
    end
    idle(1'b1);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL squash_drop got %b want 0", o_done); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      if (o_done) begin
        checks++;
        if (exp.size() == 0) begin
          errors++; $display("FAIL squash_extra got %h want none", o_pkt);
        end else if (o_pkt !== exp[0]) begin
          errors++; $display("FAIL squash_survivor got %h want %h", o_pkt, exp[0]); void'(exp.pop_front());
        end else void'(exp.pop_front());
        n++;
      end
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL squash_count got %0d want 1", n); end
  endtask

  task automatic test_clear();
    RS_PACKET m;
    FU_PACKET exp [$];
    logic [31:0] a;
    BR_TASK bt;
    int n;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      m = mk_meta(4'b0001, 4'b0110, 6'(50 + i), 5'(i));
      bt = (i == 1) ? CLEAR : BR_NONE;
      // ops already issued or accepted at the clearing edge lose the resolved bit
      exp.push_back(mk_pkt(i <= 1 ? mk_meta(4'b0001, 4'b0010, 6'(50 + i), 5'(i)) : m,
                           ref_mul(F_MULHU, a, 32'h1234_5678)));
      step(1'b1, F_MULHU, a, 32'h1234_5678, m, 1'b0, bt, 4'b0100);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      if (o_done) begin
        checks++;
        if (exp.size() == 0) begin
          errors++; $display("FAIL clear_extra got %h want none", o_pkt);
        end else begin
          if (o_pkt !== exp[0]) begin errors++; $display("FAIL clear_pkt[%0d] got %h want %h", n, o_pkt, exp[0]); end
          void'(exp.pop_front());
        end
        n++;
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL clear_count got %0d want 3", n); end
  endtask

  task automatic test_reset_mid();
    RS_PACKET m;
    int c;
    for (int i = 0; i < 3; i++) step(1'b1, F_MUL, 32'(i + 5), 32'd11, mk_meta('0, '0, 6'(60 + i), 5'(i)), 1'b0, BR_NONE, '0);
    for (int i = 3; i < STAGES; i++) idle(1'b0);
    stall = 1'b0; start = 1'b0;
    #1;
    checks++; if (fu_done !== 1'b1) begin errors++; $display("FAIL rstmid_before got %b want 1", fu_done); end
    reset = 1'b1;
    #1;
    checks++; if (fu_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b want 0", fu_done); end
    checks++; if (fu_packet !== '0) begin errors++; $display("FAIL rstmid_pkt got %h want 0", fu_packet); end
    checks++; if (free !== 1'b1) begin errors++; $display("FAIL rstmid_free got %b want 1", free); end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < STAGES + 3; i++) begin
      idle(1'b0);
      checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rstmid_stale[%0d] got %h want 0", i, o_pkt); end
    end
    m = mk_meta('0, '0, 6'd63, 5'd31);
    c = 0;
    step(1'b1, F_MULH, 32'h8000_0000, 32'h8000_0000, m, 1'b0, BR_NONE, '0);
    for (int i = 1; i <= 20 && c == 0; i++) begin
      idle(1'b0);
      if (o_done) c = i;
    end
    checks++; if (c !== STAGES) begin errors++; $display("FAIL rstmid_latency got %0d want %0d", c, STAGES); end
    checks++; if (o_pkt !== mk_pkt(m, 32'h4000_0000)) begin errors++; $display("FAIL rstmid_result got %h want %h", o_pkt, mk_pkt(m, 32'h4000_0000)); end
    flush();
  endtask

  task automatic test_random();
    FU_PACKET q [$];
    FU_PACKET prev;
    logic prev_hold;
    logic s, st;
    logic [1:0] f;
    logic [31:0] a, b;
    RS_PACKET m;
    prev = '0;
    prev_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 70);
      st = ($urandom_range(0, 99) < 30);
      f = 2'($urandom_range(0, 3));
      a = rand_operand();
      b = rand_operand();
      m = mk_meta('0, '0, 6'($urandom), 5'($urandom));
      step(s, f, a, b, m, st, BR_NONE, '0);
      if (prev_hold) begin
        checks++; if (o_pkt !== prev) begin errors++; $display("FAIL rand_stable[%0d] got %h want %h", i, o_pkt, prev); end
      end
`ifndef MULT_COLLAPSE_EN
      checks++; if (o_free !== !(o_done && st)) begin errors++; $display("FAIL rand_free[%0d] got %b want %b", i, o_free, !(o_done && st)); end
`endif
      if (s && o_free) q.push_back(mk_pkt(m, ref_mul(f, a, b)));
      if (o_done && !st) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra[%0d] got %h want none", i, o_pkt);
        end else begin
          if (o_pkt !== q[0]) begin errors++; $display("FAIL rand_pkt[%0d] got %h want %h", i, o_pkt, q[0]); end
          void'(q.pop_front());
        end
      end
      prev_hold = o_done && st;
      prev = o_pkt;
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) begin
      idle(1'b0);
      if (o_done) begin
        checks++;
        if (o_pkt !== q[0]) begin errors++; $display("FAIL rand_drain got %h want %h", o_pkt, q[0]); end
        void'(q.pop_front());
      end
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost got %0d pending want 0", q.size()); end
    idle(1'b0);
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rand_dup got %h want idle", o_pkt); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_stall();
    test_squash();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
